alu_pipe_stream: RTL
====================

// Module: alu_pipe_stream
// PURPOSE
//  Streaming successor of the two-stage ALU pipeline: valid/ready handshake on both sides,
//  configurable result depth, sideband tag carried with each op. Bubbles collapse; full stalls hold data.
//  Sits between the op issue logic and the writeback/result consumer; wraps the combinational alu.
// PARAMETERS
//  WIDTH     `WORD       operand/result width
//  OP_WIDTH  `OP_WIDTH   opcode width (encodings from the shared defines header)
//  STAGES    1           result register stages after the ALU, >=1; STAGES=0 is an elaboration error
//  TAG_W     4           sideband tag width, passed through unchanged
// PORTS
//  i_clk      in   1         clock, rising edge
//  i_rst      in   1         reset, asynchronous, active-high
//  i_a        in   WIDTH     operand A
//  i_b        in   WIDTH     operand B
//  i_opcode   in   OP_WIDTH  ALU opcode
//  i_tag      in   TAG_W     sideband tag
//  i_valid    in   1         input beat valid
//  o_ready    out  1         pipeline accepts input beat this cycle
//  o_result   out  WIDTH     ALU result
//  o_zero     out  1         result == 0
//  o_cf       out  1         carry/borrow flag from ALU
//  o_tag      out  TAG_W     tag of the op on o_result
//  o_valid    out  1         output beat valid
//  i_ready    in   1         consumer accepts output beat
//  i_flush    in   1         (only with ALU_PIPE_FLUSH_EN) drop all in-flight ops
// BEHAVIOUR
//  - Stage 0 registers a/b/opcode/tag; alu evaluates stage 0 combinationally; stages 1..STAGES hold
//    result/zero/cf/tag. Last stage drives outputs directly.
//  - Per-stage valid v[k]. Enable chain: en[STAGES] = !v[STAGES] | i_ready; en[k] = !v[k] | en[k+1].
//  - o_ready = en[0] (combinational from i_ready through the chain; no registered ready).
//  - Transfer in: i_valid & o_ready. Transfer out: o_valid & i_ready. o_valid = v[STAGES].
//  - When en[k]: v[k] <= v[k-1] (stage 0: v[0] <= i_valid); data loads only if incoming valid, else holds.
//  - Latency: STAGES+1 cycles from input transfer to o_valid with i_ready held high; throughput 1/clk.
//  - Stall: o_valid & !i_ready -> o_result/o_zero/o_cf/o_tag stable until accepted; upstream fills
//    bubbles; o_ready falls only when all STAGES+1 slots are valid.
//  - Simultaneous in/out on a full pipe: both transfers occur, occupancy unchanged, no beat lost.
//  - Ordering strictly FIFO; no op dropped or duplicated (flush excepted).
//  - Reset: all v[k]=0, o_valid=0, o_result=0, o_zero=0, o_cf=0, o_tag=0, o_ready=1 after reset.
//    Reset mid-stream discards every in-flight op; first post-reset output is the first post-reset input.
//  - Flags computed by alu on the stage-0 operands and carried with the result, never recomputed.
// CONFIGURATION
//  ALU_PIPE_FLUSH_EN defined: i_flush port exists; i_flush=1 clears all v[k] on next edge, data regs
//    untouched, o_ready forced 0 during the flush cycle (input beat not accepted); flush wins over in/out.
//  Undefined: no i_flush port; pipeline only emptied by draining or reset.
// STRUCTURE
//  - Shared defines header: `WORD, `OP_WIDTH, opcode encodings (ADD, SUB, AND, OR, XOR...).
//  - Sub-module alu_pipe_slice: one result stage (result, zero, cf, tag, valid) with enable/flush;
//    instantiated STAGES times in a generate loop. Existing combinational alu instanced once.
// TESTING (bench WIDTH=8, STAGES=2, TAG_W=4)
//  - Reset: assert i_rst mid-stream with 3 ops in flight -> o_valid=0, outputs 0, o_ready=1; none emerge.
//  - Streaming: ADD 8'h05+8'h03 tag 1, then ADD 8'hFF+8'h01 tag 2 back-to-back, i_ready=1 ->
//    cycle 3: 8'h08 z=0 cf=0 tag1; cycle 4: 8'h00 z=1 cf=1 tag2.
//  - Backpressure: i_ready=0, push 4 ops -> 3 accepted, o_ready=0, o_result frozen at op1; release ->
//    ops 1..4 out in order on consecutive cycles.
//  - Full-pipe pass-through: pipe full, i_valid=1 and i_ready=1 same cycle -> one in, one out, o_ready=1.
//  - Bubbles: random i_valid/i_ready 10k ops vs reference model -> results/flags/tags match, order kept.
//  - Flush (ALU_PIPE_FLUSH_EN): 3 ops in flight, pulse i_flush -> o_valid=0 next cycle, none emerge;
//    op pushed cycle after emerges with latency 3.

Source files
------------

// File: rtl/alu_pipe_stream_pkg.sv
// Shared ALU definitions for the streaming ALU pipeline: default widths and opcode encodings.
package alu_pipe_stream_pkg;

   localparam int ALU_WORD     = 16;
   localparam int ALU_OP_WIDTH = 3;

   typedef enum logic [ALU_OP_WIDTH-1:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4
   } alu_op_e;

endpackage

// File: rtl/alu_pipe_stream_alu.sv
// Combinational ALU: result, zero flag and carry/borrow flag from two operands and an opcode.
module alu
   import alu_pipe_stream_pkg::*;
#(
   parameter int WIDTH    = ALU_WORD,
   parameter int OP_WIDTH = ALU_OP_WIDTH
)(
   input  logic [WIDTH-1:0]    a_i,
   input  logic [WIDTH-1:0]    b_i,
   input  logic [OP_WIDTH-1:0] opcode_i,
   output logic [WIDTH-1:0]    result_o,
   output logic                zero_o,
   output logic                cf_o
);

   logic [WIDTH:0] sum_w;
   logic [WIDTH:0] diff_w;

   assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
   assign diff_w = {1'b0, a_i} - {1'b0, b_i};

   // Unused encodings yield zero with no carry.
   always_comb begin
      result_o = '0;
      cf_o     = 1'b0;
      case (opcode_i)
         OP_ADD: {cf_o, result_o} = sum_w;
         OP_SUB: {cf_o, result_o} = diff_w;
         OP_AND: result_o = a_i & b_i;
         OP_OR:  result_o = a_i | b_i;
         OP_XOR: result_o = a_i ^ b_i;
         default: ;
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_pipe_stream_slice.sv
// One result stage of the ALU pipeline: holds result, flags and tag; advances on enable.
module alu_pipe_slice #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             flush_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] result_i,
   input  logic             zero_i,
   input  logic             cf_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             cf_o,
   output logic [TAG_W-1:0] tag_o
);

   // A bubble moving in leaves the old data in place; only the valid bit changes.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_o  <= 1'b0;
         result_o <= '0;
         zero_o   <= 1'b0;
         cf_o     <= 1'b0;
         tag_o    <= '0;
      end else if (flush_i) begin
         valid_o <= 1'b0;
      end else if (en_i) begin
         valid_o <= valid_i;
         if (valid_i) begin
            result_o <= result_i;
            zero_o   <= zero_i;
            cf_o     <= cf_i;
            tag_o    <= tag_i;
         end
      end
   end

endmodule

// File: rtl/alu_pipe_stream.sv
// Streaming ALU pipeline with valid/ready on both sides and STAGES result registers.
// Optional i_flush port enabled by defining ALU_PIPE_FLUSH_EN.
module alu_pipe_stream
   import alu_pipe_stream_pkg::*;
#(
   parameter int WIDTH    = ALU_WORD,
   parameter int OP_WIDTH = ALU_OP_WIDTH,
   parameter int STAGES   = 1,
   parameter int TAG_W    = 4
)(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [WIDTH-1:0]    i_a,
   input  logic [WIDTH-1:0]    i_b,
   input  logic [OP_WIDTH-1:0] i_opcode,
   input  logic [TAG_W-1:0]    i_tag,
   input  logic                i_valid,
   output logic                o_ready,
   output logic [WIDTH-1:0]    o_result,
   output logic                o_zero,
   output logic                o_cf,
   output logic [TAG_W-1:0]    o_tag,
   output logic                o_valid,
   input  logic                i_ready
`ifdef ALU_PIPE_FLUSH_EN
   ,
   input  logic                i_flush
`endif
);

   if (STAGES < 1) begin : g_bad_stages
      $error("alu_pipe_stream: STAGES must be >= 1");
   end

   logic [STAGES:0]   v;
   logic [STAGES:0]   en;
   logic              flush;
   logic              full;

   logic              v0_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [OP_WIDTH-1:0] op_q;
   logic [TAG_W-1:0]  tag_q;

   logic [WIDTH-1:0]  res_s  [0:STAGES];
   logic              zero_s [0:STAGES];
   logic              cf_s   [0:STAGES];
   logic [TAG_W-1:0]  tag_s  [0:STAGES];

`ifdef ALU_PIPE_FLUSH_EN
   assign flush = i_flush;
`else
   assign flush = 1'b0;
`endif

   // Flattened enable chain: slot k may advance when the consumer is ready or any slot k..STAGES is empty.
   always_comb begin
      en   = '0;
      full = 1'b1;
      for (int k = 0; k <= STAGES; k++) begin
         full = 1'b1;
         for (int j = k; j <= STAGES; j++) begin
            full = full & v[j];
         end
         en[k] = ~full | i_ready;
      end
   end

   assign o_ready = en[0] & ~flush;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         v0_q  <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         tag_q <= '0;
      end else if (flush) begin
         v0_q <= 1'b0;
      end else if (en[0]) begin
         v0_q <= i_valid;
         if (i_valid) begin
            a_q   <= i_a;
            b_q   <= i_b;
            op_q  <= i_opcode;
            tag_q <= i_tag;
         end
      end
   end

   alu #(
      .WIDTH    (WIDTH),
      .OP_WIDTH (OP_WIDTH)
   ) u_alu (
      .a_i      (a_q),
      .b_i      (b_q),
      .opcode_i (op_q),
      .result_o (res_s[0]),
      .zero_o   (zero_s[0]),
      .cf_o     (cf_s[0])
   );

   assign v[0]     = v0_q;
   assign tag_s[0] = tag_q;

   for (genvar k = 1; k <= STAGES; k++) begin : g_stage
      alu_pipe_slice #(
         .WIDTH (WIDTH),
         .TAG_W (TAG_W)
      ) u_slice (
         .clk_i    (i_clk),
         .rst_i    (i_rst),
         .en_i     (en[k]),
         .flush_i  (flush),
         .valid_i  (v[k-1]),
         .result_i (res_s[k-1]),
         .zero_i   (zero_s[k-1]),
         .cf_i     (cf_s[k-1]),
         .tag_i    (tag_s[k-1]),
         .valid_o  (v[k]),
         .result_o (res_s[k]),
         .zero_o   (zero_s[k]),
         .cf_o     (cf_s[k]),
         .tag_o    (tag_s[k])
      );
   end

   assign o_valid  = v[STAGES];
   assign o_result = res_s[STAGES];
   assign o_zero   = zero_s[STAGES];
   assign o_cf     = cf_s[STAGES];
   assign o_tag    = tag_s[STAGES];

endmodule
